adc_serial_rx: RTL and testbench

- Upstream front end of the anti-aliasing filter chain.
- Drives a 24-bit delta-sigma ADC serial port: generates SCLK from `clk`, detects the DRDY falling edge, and shifts in DOUT MSB-first.
- Presents each completed word as a signed 24-bit sample with a one-cycle valid pulse, which feeds the first filter's `original_data_in`/`valid_in`.
- Flags aborted (overrun) frames.

---
 rtl/adc_rx_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/adc_serial_rx.sv | 194 +++++++++++++++++++
 tb/tb_adc_serial_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_rx_pkg.sv
// Shared types and constants for the ADC serial receiver.
package adc_rx_pkg;

    localparam int DATA_W_DEF = 24;

    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/adc_serial_rx.sv
// Serial receiver for a 24-bit delta-sigma ADC: SCLK generation, DRDY edge start, MSB-first capture.
// Optional ADC_RX_OFFSET_EN adds offset_in and a saturating subtract stage (one extra clk of latency).
//
// state | meaning
// IDLE  | waiting for a DRDY falling edge while en is high
// SHIFT | toggling adc_sclk, capturing one bit per SCLK fall
// DONE  | publishing the assembled word, then back to IDLE
module adc_serial_rx
    import adc_rx_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              adc_drdy_n,
    input  logic              adc_dout,
`ifdef ADC_RX_OFFSET_EN
    input  logic [DATA_W-1:0] offset_in,
`endif
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    if (SCLK_DIV < 3) begin : g_div_chk
        $error("adc_serial_rx: SCLK_DIV must be at least 3");
    end

    logic              drdy_s;
    logic              dout_s;
    logic              drdy_fall;

    rx_state_t         state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sclk_q, sclk_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] raw_sample_q, raw_sample_d;
    logic              raw_valid_q, raw_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              drdy_prev_q, drdy_prev_d;
    logic [1:0]        warm_q, warm_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_drdy (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_drdy_n),
        .q     (drdy_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_dout (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_dout),
        .q     (dout_s)
    );

    // A pin already low at reset release must not look like an edge: mask until the sync chain holds real data.
    assign drdy_fall = (warm_q == 2'd0) && drdy_prev_q && !drdy_s;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_cnt_d    = bit_cnt_q;
        sclk_d       = sclk_q;
        shift_d      = shift_q;
        raw_sample_d = raw_sample_q;
        raw_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
        drdy_prev_d  = drdy_s;
        warm_d       = (warm_q != 2'd0) ? warm_q - 2'd1 : warm_q;

        case (state_q)
            ST_IDLE: begin
                if (drdy_fall && en) begin
                    state_d   = ST_SHIFT;
                    div_d     = '0;
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (drdy_fall) begin
                    frame_err_d = 1'b1;
                    div_d       = '0;
                    bit_cnt_d   = '0;
                    sclk_d      = 1'b0;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    if (sclk_q) begin
                        shift_d   = {shift_q[DATA_W-2:0], dout_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DONE: begin
                raw_sample_d = shift_q;
                raw_valid_d  = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

`ifdef ADC_RX_OFFSET_EN
    localparam logic [DATA_W-1:0] SAT_HI = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_LO = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0]   diff_w;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    assign diff_w = {raw_sample_q[DATA_W-1], raw_sample_q} - {offset_in[DATA_W-1], offset_in};

    always_comb begin
        out_d       = out_q;
        out_valid_d = raw_valid_q;
        if (raw_valid_q) begin
            if (diff_w[DATA_W] != diff_w[DATA_W-1]) begin
                out_d = diff_w[DATA_W] ? SAT_LO : SAT_HI;
            end else begin
                out_d = diff_w[DATA_W-1:0];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            sclk_q       <= 1'b0;
            shift_q      <= '0;
            raw_sample_q <= '0;
            raw_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            drdy_prev_q  <= 1'b1;
            warm_q       <= 2'd3;
`ifdef ADC_RX_OFFSET_EN
            out_q        <= '0;
            out_valid_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            sclk_q       <= sclk_d;
            shift_q      <= shift_d;
            raw_sample_q <= raw_sample_d;
            raw_valid_q  <= raw_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            drdy_prev_q  <= drdy_prev_d;
            warm_q       <= warm_d;
`ifdef ADC_RX_OFFSET_EN
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
`endif
        end
    end

    assign adc_sclk  = sclk_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

`ifdef ADC_RX_OFFSET_EN
    assign sample_out   = out_q;
    assign sample_valid = out_valid_q;
`else
    assign sample_out   = raw_sample_q;
    assign sample_valid = raw_valid_q;
`endif

endmodule

// File: tb/tb_adc_serial_rx.sv
// Self-checking bench for adc_serial_rx with a behavioural ADC and a word-level reference model.
`timescale 1ns/1ps
module tb_adc_serial_rx;

    localparam int DW    = 24;
    localparam int DIV   = 4;
    localparam int FRAME = 2 * DW * DIV;
`ifdef ADC_RX_OFFSET_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          adc_drdy_n = 1'b1;
    logic          adc_dout;
    logic          adc_sclk;
    logic [DW-1:0] sample_out;
    logic          sample_valid;
    logic          frame_err;
    logic          busy;
    int            off_val = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef ADC_RX_OFFSET_EN
    logic [DW-1:0] offset_in;
    assign offset_in = DW'(off_val);
`endif

    adc_serial_rx #(.DATA_W(DW), .SCLK_DIV(DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .adc_drdy_n   (adc_drdy_n),
        .adc_dout     (adc_dout),
`ifdef ADC_RX_OFFSET_EN
        .offset_in    (offset_in),
`endif
        .adc_sclk     (adc_sclk),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    // ADC model: MSB appears when DRDY falls, next bit after every SCLK fall.
    int            adc_falls = 0;
    int            tx_base = 0;
    int            tx_k;
    logic [DW-1:0] tx_word = '0;

    always @(negedge adc_sclk) adc_falls = adc_falls + 1;

    always_comb begin
        tx_k = (DW - 1) - (adc_falls - tx_base);
        if (tx_k < 0) tx_k = 0;
        adc_dout = tx_word[tx_k];
    end

    // Monitor, sampled mid-cycle.
    int            cyc = 0, rise_cnt = 0, fall_cnt = 0, busy_cnt = 0;
    int            valid_cnt = 0, err_cnt = 0, last_fall_cyc = 0, valid_cyc = 0;
    logic [DW-1:0] last_sample = '0;
    logic          sclk_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (adc_sclk && !sclk_prev) rise_cnt = rise_cnt + 1;
        if (!adc_sclk && sclk_prev) begin
            fall_cnt      = fall_cnt + 1;
            last_fall_cyc = cyc;
        end
        sclk_prev = adc_sclk;
        if (busy) busy_cnt = busy_cnt + 1;
        if (frame_err) err_cnt = err_cnt + 1;
        if (sample_valid) begin
            valid_cnt   = valid_cnt + 1;
            valid_cyc   = cyc;
            last_sample = sample_out;
        end
    end

    function automatic logic [DW-1:0] ref_sample(input logic [DW-1:0] w, input int off);
        longint v;
        v = longint'($signed(w)) - longint'(off);
        if (v > 64'sd8388607)  v = 64'sd8388607;
        if (v < -64'sd8388608) v = -64'sd8388608;
        return DW'(v);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [DW-1:0] w);
        tx_word    = w;
        tx_base    = adc_falls;
        adc_drdy_n = 1'b0;
        repeat (4) tick();
        adc_drdy_n = 1'b1;
    endtask

    task automatic wait_valid(input int base, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME + 100; i++) begin
            if (valid_cnt > base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no sample_valid within %0d clk", name, FRAME + 100);
        end
    endtask

    task automatic wait_falls(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < FRAME + 50; i++) begin
            if (fall_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: sclk fall count stuck at %0d, wanted %0d", name, fall_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (adc_sclk !== 1'b0)    begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", adc_sclk); end
        n_checks++; if (sample_out !== '0)    begin n_fail++; $display("FAIL reset_sample: got %h expected 0", sample_out); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
        n_checks++; if (frame_err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_basic();
        int b_v, b_e, b_r, b_b;
        bit ok;
        logic [DW-1:0] exp_s;
        b_v = valid_cnt; b_e = err_cnt; b_r = rise_cnt; b_b = busy_cnt;
        exp_s = ref_sample(24'h123456, off_val);
        start_frame(24'h123456);
        wait_valid(b_v, "basic", ok);
        repeat (20) tick();
        n_checks++; if (rise_cnt - b_r !== DW)   begin n_fail++; $display("FAIL basic_sclk_pulses: got %0d expected %0d", rise_cnt - b_r, DW); end
        n_checks++; if (busy_cnt - b_b !== FRAME) begin n_fail++; $display("FAIL basic_busy_len: got %0d expected %0d", busy_cnt - b_b, FRAME); end
        n_checks++; if (sample_out !== exp_s)     begin n_fail++; $display("FAIL basic_sample: got %h expected %h", sample_out, exp_s); end
        n_checks++; if (valid_cnt - b_v !== 1)    begin n_fail++; $display("FAIL basic_valid_width: got %0d expected 1", valid_cnt - b_v); end
        n_checks++; if (err_cnt - b_e !== 0)      begin n_fail++; $display("FAIL basic_frame_err: got %0d expected 0", err_cnt - b_e); end
        n_checks++; if (valid_cyc - last_fall_cyc !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", valid_cyc - last_fall_cyc, LAT); end
    endtask

    task automatic test_extremes();
        logic [DW-1:0] words[6];
        logic [DW-1:0] exp_s;
        int b_v, b_e;
        bit ok;
        words[0] = 24'h800000;
        words[1] = 24'h7FFFFF;
        for (int i = 2; i < 6; i++) words[i] = DW'($urandom);
        for (int i = 0; i < 6; i++) begin
            b_v = valid_cnt; b_e = err_cnt;
            exp_s = ref_sample(words[i], off_val);
            start_frame(words[i]);
            wait_valid(b_v, "extremes", ok);
            repeat (10) tick();
            n_checks++; if (sample_out !== exp_s) begin n_fail++; $display("FAIL extremes_sample[%0d]: got %h expected %h", i, sample_out, exp_s); end
            n_checks++; if ((valid_cnt - b_v !== 1) || (err_cnt - b_e !== 0)) begin
                n_fail++; $display("FAIL extremes_pulses[%0d]: valids %0d errs %0d expected 1 and 0", i, valid_cnt - b_v, err_cnt - b_e);
            end
        end
    endtask

    task automatic test_overrun();
        int b_v, b_e, b_f;
        bit ok;
        logic [DW-1:0] exp_s;
        b_v = valid_cnt; b_e = err_cnt; b_f = fall_cnt;
        exp_s = ref_sample(24'h00000F, off_val);
        start_frame(DW'($urandom));
        wait_falls(b_f + 10, "overrun_bits");
        start_frame(24'h00000F);
        wait_valid(b_v, "overrun", ok);
        repeat (20) tick();
        n_checks++; if (err_cnt - b_e !== 1)   begin n_fail++; $display("FAIL overrun_err: got %0d expected 1", err_cnt - b_e); end
        n_checks++; if (valid_cnt - b_v !== 1) begin n_fail++; $display("FAIL overrun_valids: got %0d expected 1", valid_cnt - b_v); end
        n_checks++; if (sample_out !== exp_s)  begin n_fail++; $display("FAIL overrun_sample: got %h expected %h", sample_out, exp_s); end
    endtask

    task automatic test_enable();
        int b_v, b_r, b_b;
        bit ok;
        logic [DW-1:0] w, exp_s;
        en = 1'b0;
        b_v = valid_cnt; b_r = rise_cnt; b_b = busy_cnt;
        for (int i = 0; i < 3; i++) begin
            start_frame(DW'($urandom));
            repeat (30) tick();
        end
        n_checks++; if (rise_cnt - b_r !== 0) begin n_fail++; $display("FAIL en_off_sclk: got %0d pulses expected 0", rise_cnt - b_r); end
        n_checks++; if (busy_cnt - b_b !== 0) begin n_fail++; $display("FAIL en_off_busy: got %0d clk expected 0", busy_cnt - b_b); end
        n_checks++; if (valid_cnt - b_v !== 0) begin n_fail++; $display("FAIL en_off_valid: got %0d expected 0", valid_cnt - b_v); end
        en = 1'b1;
        b_v = valid_cnt; b_r = rise_cnt;
        w = DW'($urandom);
        exp_s = ref_sample(w, off_val);
        start_frame(w);
        en = 1'b0;
        wait_valid(b_v, "en_midframe", ok);
        repeat (10) tick();
        n_checks++; if (sample_out !== exp_s) begin n_fail++; $display("FAIL en_midframe_sample: got %h expected %h", sample_out, exp_s); end
        n_checks++; if (rise_cnt - b_r !== DW) begin n_fail++; $display("FAIL en_midframe_pulses: got %0d expected %0d", rise_cnt - b_r, DW); end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int b_v, b_f, b_r, b_b;
        bit ok;
        logic [DW-1:0] w, exp_s;
        b_f = fall_cnt;
        start_frame(DW'($urandom));
        wait_falls(b_f + 12, "rst_mid_bits");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sclk: got %b expected 0", adc_sclk); end
        n_checks++; if (sample_out !== '0) begin n_fail++; $display("FAIL rst_mid_sample: got %h expected 0", sample_out); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        b_v = valid_cnt;
        repeat (FRAME + 20) tick();
        n_checks++; if (valid_cnt - b_v !== 0) begin n_fail++; $display("FAIL rst_mid_valid: got %0d expected 0", valid_cnt - b_v); end

        adc_drdy_n = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        b_r = rise_cnt; b_b = busy_cnt;
        repeat (30) tick();
        n_checks++; if ((busy_cnt - b_b !== 0) || (rise_cnt - b_r !== 0)) begin
            n_fail++; $display("FAIL low_at_release: busy %0d clk, %0d sclk pulses, expected 0 and 0", busy_cnt - b_b, rise_cnt - b_r);
        end
        adc_drdy_n = 1'b1;
        repeat (5) tick();
        b_v = valid_cnt;
        w = DW'($urandom);
        exp_s = ref_sample(w, off_val);
        start_frame(w);
        wait_valid(b_v, "after_release", ok);
        repeat (10) tick();
        n_checks++; if (sample_out !== exp_s) begin n_fail++; $display("FAIL after_release_sample: got %h expected %h", sample_out, exp_s); end
    endtask

`ifdef ADC_RX_OFFSET_EN
    task automatic test_offset();
        int b_v;
        bit ok;
        off_val = -32;
        b_v = valid_cnt;
        start_frame(24'h7FFFF0);
        wait_valid(b_v, "offset_pos", ok);
        repeat (10) tick();
        n_checks++; if (sample_out !== 24'h7FFFFF) begin n_fail++; $display("FAIL offset_sat_hi: got %h expected 7fffff", sample_out); end
        n_checks++; if (valid_cyc - last_fall_cyc !== 2) begin n_fail++; $display("FAIL offset_latency: got %0d expected 2", valid_cyc - last_fall_cyc); end
        off_val = 32;
        b_v = valid_cnt;
        start_frame(24'h800010);
        wait_valid(b_v, "offset_neg", ok);
        repeat (10) tick();
        n_checks++; if (sample_out !== 24'h800000) begin n_fail++; $display("FAIL offset_sat_lo: got %h expected 800000", sample_out); end
        off_val = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_overrun();
        test_enable();
        test_reset_mid();
`ifdef ADC_RX_OFFSET_EN
        test_offset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
